// File: rtl/sec32_encode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sec32_encode_pipe
// Purpose  : Computes the SEC check byte for a 32-bit word. It buffers each
//            {en, check, data} codeword in a 2-entry FIFO that faces a
//            downstream SEC decoder. A one-shot error injector can flip any
//            single codeword bit. A saturating counter tracks the number of
//            codewords delivered.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            in_valid/in_ready     - upstream handshake (data_in, en_in)
//            out_valid/out_ready   - downstream handshake (data_out,
//                                    check_out, en_out)
//            inj_arm/inj_bit       - arm one-shot flip of codeword bit 0..39
//            inj_pending           - injection armed, not yet applied
//            word_cnt              - delivered codeword count (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module sec32_encode_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      data_in,
    input  logic             en_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      data_out,
    output logic [7:0]       check_out,
    output logic             en_out,
    input  logic             inj_arm,
    input  logic [5:0]       inj_bit,
    output logic             inj_pending,
    output logic [CNT_W-1:0] word_cnt
);

    // Codeword layout: [40] en, [39:32] c[7:0], [31:0] d[31:0].
    localparam int         c_CODE_W  = 41;
    localparam logic [5:0] c_MAX_BIT = 6'd39;

    function automatic logic [7:0] encode(input logic [31:0] d);
        logic [7:0] c;
        c[0] = (^d[23:16]) ^ d[0] ^ d[4] ^ d[8]  ^ d[12];
        c[1] = (^d[31:24]) ^ d[1] ^ d[5] ^ d[9]  ^ d[13];
        c[2] = (^d[19:16]) ^ (^d[27:24]) ^ d[2] ^ d[6] ^ d[10] ^ d[14];
        c[3] = (^d[23:20]) ^ (^d[31:28]) ^ d[3] ^ d[7] ^ d[11] ^ d[15];
        c[4] = (^d[7:0])   ^ d[16] ^ d[20] ^ d[24] ^ d[28];
        c[5] = (^d[15:8])  ^ d[17] ^ d[21] ^ d[25] ^ d[29];
        c[6] = (^d[3:0])   ^ (^d[11:8])  ^ d[18] ^ d[22] ^ d[26] ^ d[30];
        c[7] = (^d[7:4])   ^ (^d[15:12]) ^ d[19] ^ d[23] ^ d[27] ^ d[31];
        return c;
    endfunction

    logic [c_CODE_W-1:0] r_mem [2];
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_count;
    logic                r_inj_pending;
    logic [5:0]          r_inj_idx;
    logic [CNT_W-1:0]    r_word_cnt;

    logic                w_accept;
    logic                w_deliver;
    logic [c_CODE_W-1:0] w_code;

    // Ready comes straight from the occupancy register, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready  = (r_count < 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_accept  = in_valid & in_ready;
    assign w_deliver = out_valid & out_ready;

    assign {en_out, check_out, data_out} = r_mem[r_rd_ptr];
    assign inj_pending = r_inj_pending;
    assign word_cnt    = r_word_cnt;

    // Build the codeword. The pending flip is applied after encoding, so the
    // decoder sees a genuine single-bit error.
    always_comb begin
        w_code = {en_in, encode(data_in), data_in};
        if (r_inj_pending) begin
            for (int i = 0; i < 40; i++) begin
                if (r_inj_idx == 6'(i)) begin
                    w_code[i] = ~w_code[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0]      <= '0;
            r_mem[1]      <= '0;
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_count       <= 2'd0;
            r_inj_pending <= 1'b0;
            r_inj_idx     <= 6'd0;
            r_word_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_mem[r_wr_ptr] <= w_code;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_deliver) begin
                r_rd_ptr <= ~r_rd_ptr;
                if (r_word_cnt != {CNT_W{1'b1}}) begin
                    r_word_cnt <= r_word_cnt + CNT_W'(1);
                end
            end
            case ({w_accept, w_deliver})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            // A word accepted on this edge consumes the injection that was
            // already pending. An arm arriving on this edge is written after
            // that, so it targets the next word and overrides the clear.
            if (w_accept && r_inj_pending) begin
                r_inj_pending <= 1'b0;
            end
            if (inj_arm && (inj_bit <= c_MAX_BIT)) begin
                r_inj_pending <= 1'b1;
                r_inj_idx     <= inj_bit;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sec32_encode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_sec32_encode_pipe
// Purpose  : Self-checking bench for sec32_encode_pipe (CNT_W = 4). It uses an
//            encoding table plus hand-written handshake, injection, reset and
//            saturation sequences. A queue scoreboard tracks every codeword.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sec32_encode_pipe;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      data_in;
    logic             en_in;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      data_out;
    logic [7:0]       check_out;
    logic             en_out;
    logic             inj_arm;
    logic [5:0]       inj_bit;
    logic             inj_pending;
    logic [CNT_W-1:0] word_cnt;

    sec32_encode_pipe #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .data_in     (data_in),
        .en_in       (en_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .data_out    (data_out),
        .check_out   (check_out),
        .en_out      (en_out),
        .inj_arm     (inj_arm),
        .inj_bit     (inj_bit),
        .inj_pending (inj_pending),
        .word_cnt    (word_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        en;
        logic [7:0]  check;
    } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [40:0] sb_q [$];
    logic        m_pend;
    logic [5:0]  m_idx;
    int          m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Each check bit is the parity of the data bits in its mask column.
    function automatic logic [7:0] model_check(input logic [31:0] d);
        logic [31:0] m [8];
        logic [7:0]  c;
        m[0] = 32'h00FF1111; m[1] = 32'hFF002222;
        m[2] = 32'h0F0F4444; m[3] = 32'hF0F08888;
        m[4] = 32'h111100FF; m[5] = 32'h2222FF00;
        m[6] = 32'h44440F0F; m[7] = 32'h8888F0F0;
        for (int k = 0; k < 8; k++) c[k] = ^(d & m[k]);
        return c;
    endfunction

    // One clock cycle: compare DUT state with the model, update the model
    // from the handshakes on this edge, then advance to the next negedge.
    task automatic step();
        logic        acc;
        logic        dlv;
        logic [39:0] code;
        logic [40:0] head;
        #1;
        chk("in_ready", in_ready, (sb_q.size() < 2));
        chk("out_valid", out_valid, (sb_q.size() > 0));
        chk("inj_pending", inj_pending, m_pend);
        chk("word_cnt", word_cnt, m_cnt);
        if (out_valid && sb_q.size() > 0) begin
            head = sb_q[0];
            chk("head", {en_out, check_out, data_out}, head);
        end
        if (rst) begin
            sb_q.delete();
            m_pend = 1'b0;
            m_idx  = 6'd0;
            m_cnt  = 0;
        end else begin
            acc = in_valid & in_ready;
            dlv = out_valid & out_ready;
            if (dlv && sb_q.size() > 0) begin
                void'(sb_q.pop_front());
                if (m_cnt < 15) m_cnt++;
            end
            if (acc) begin
                code = {model_check(data_in), data_in};
                if (m_pend) begin
                    code[m_idx] = ~code[m_idx];
                    m_pend = 1'b0;
                end
                sb_q.push_back({en_in, code});
            end
            if (inj_arm && inj_bit <= 6'd39) begin
                m_pend = 1'b1;
                m_idx  = inj_bit;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        inj_arm   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) step();
        chk("drain_timeout", sb_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        tbl[0] = '{32'h00000001, 1'b1, 8'h51};
        tbl[1] = '{32'h00010000, 1'b0, 8'h15};
        tbl[2] = '{32'hFFFFFFFF, 1'b1, 8'h00};
        tbl[3] = '{32'h00000000, 1'b0, 8'h00};
        tbl[4] = '{32'h00000002, 1'b1, 8'h52};
        tbl[5] = '{32'h80000000, 1'b0, 8'h8A};
        tbl[6] = '{32'h00000100, 1'b1, 8'h61};

        rst = 1'b1; in_valid = 1'b0; data_in = '0; en_in = 1'b0;
        out_ready = 1'b0; inj_arm = 1'b0; inj_bit = '0;
        m_pend = 1'b0; m_idx = '0; m_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_inj_pending", inj_pending, 0);
        chk("rst_word_cnt", word_cnt, 0);

        // Table encodings, one word per cycle with one cycle of latency.
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; data_in = tbl[i].data; en_in = tbl[i].en;
            step();
            #1;
            chk("tbl_valid", out_valid, 1);
            chk("tbl_ready", in_ready, 1);
            chk("tbl_data", data_out, tbl[i].data);
            chk("tbl_check", check_out, tbl[i].check);
            chk("tbl_en", en_out, tbl[i].en);
        end
        drain();
        chk("flow_cnt", word_cnt, 7);

        // Backpressure: two accepted, the third waits for space.
        out_ready = 1'b0; en_in = 1'b0; in_valid = 1'b1;
        data_in = 32'h11111111; step();
        data_in = 32'h22222222; step();
        #1; chk("bp_full", in_ready, 0);
        data_in = 32'h33333333; step();
        #1; chk("bp_head", data_out, 32'h11111111);
        out_ready = 1'b1; step();
        #1; chk("bp_ready_again", in_ready, 1);
        chk("bp_head2", data_out, 32'h22222222);
        step();
        drain();

        // Injection on c0.
        inj_arm = 1'b1; inj_bit = 6'd32; step();
        inj_arm = 1'b0;
        #1; chk("inj_armed", inj_pending, 1);
        in_valid = 1'b1; data_in = '0; step();
        in_valid = 1'b0;
        #1; chk("inj_cleared", inj_pending, 0);
        chk("inj_c0", check_out, 8'h01);
        drain();
        // Injection on data bit 5.
        inj_arm = 1'b1; inj_bit = 6'd5; step();
        inj_arm = 1'b0; in_valid = 1'b1; data_in = '0; step();
        in_valid = 1'b0;
        #1; chk("inj_d5_data", data_out, 32'h20);
        chk("inj_d5_check", check_out, 8'h00);
        drain();
        // Out-of-range index is ignored.
        inj_arm = 1'b1; inj_bit = 6'd45; step();
        inj_arm = 1'b0;
        #1; chk("inj45_pending", inj_pending, 0);
        in_valid = 1'b1; data_in = '0; step();
        in_valid = 1'b0;
        #1; chk("inj45_check", check_out, 8'h00);
        drain();
        // Re-arm overwrites the stored index.
        inj_arm = 1'b1; inj_bit = 6'd3; step();
        inj_bit = 6'd33; step();
        inj_arm = 1'b0; in_valid = 1'b1; data_in = '0; step();
        in_valid = 1'b0;
        #1; chk("rearm_check", check_out, 8'h02);
        chk("rearm_data", data_out, 32'h0);
        drain();
        // Arm together with acceptance hits the following word.
        in_valid = 1'b1; data_in = '0; inj_arm = 1'b1; inj_bit = 6'd0; step();
        inj_arm = 1'b0;
        #1; chk("same_cycle_first", data_out, 32'h0);
        step();
        #1; chk("same_cycle_second", data_out, 32'h1);
        drain();

        // Reset with two words buffered and an injection pending.
        out_ready = 1'b0; in_valid = 1'b1;
        data_in = 32'hA5A5A5A5; step();
        data_in = 32'h5A5A5A5A; step();
        in_valid = 1'b0; inj_arm = 1'b1; inj_bit = 6'd7; step();
        inj_arm = 1'b0;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; step();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_inj", inj_pending, 0);
        chk("mid_rst_cnt", word_cnt, 0);

        // Counter saturation.
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data_in = $urandom; en_in = 1'($urandom_range(0, 1));
            step();
        end
        drain();
        chk("sat_cnt", word_cnt, 15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sec32_encode_pipe.md
SEC32_ENCODE_PIPE -- requirements
Module: sec32_encode_pipe

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the encoded-word counter.
REQ-002 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: upstream word valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept a word.
REQ-006 SHALL have port data_in, input, 32 bits: payload, bit k = d[k].
REQ-007 SHALL have port en_in, input, 1 bit: correction-enable flag carried with the word.
REQ-008 SHALL have port out_valid, output, 1 bit: codeword available.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream SEC decoder stage accepts the codeword.
REQ-010 SHALL have port data_out, output, 32 bits: data bits, feeding decoder data inputs in ascending order.
REQ-011 SHALL have port check_out, output, 8 bits: check bits c[7:0], feeding decoder check inputs in ascending order.
REQ-012 SHALL have port en_out, output, 1 bit: correction enable that drives the decoder enable input.
REQ-013 SHALL have port inj_arm, input, 1 bit: single-cycle pulse that arms one-shot error injection.
REQ-014 SHALL have port inj_bit, input, 6 bits: codeword bit to flip, where 0-31 is data and 32-39 is c[0..7].
REQ-015 SHALL have port inj_pending, output, 1 bit: injection armed and not yet applied.
REQ-016 SHALL have port word_cnt, output, CNT_W bits: count of codewords delivered downstream.

Function
REQ-017 SHALL compute even check bits from the word at acceptance as follows:
- c0 = ^d[23:16] ^ d0^d4^d8^d12
- c1 = ^d[31:24] ^ d1^d5^d9^d13
- c2 = ^d[19:16] ^ ^d[27:24] ^ d2^d6^d10^d14
- c3 = ^d[23:20] ^ ^d[31:28] ^ d3^d7^d11^d15
- c4 = ^d[7:0] ^ d16^d20^d24^d28
- c5 = ^d[15:8] ^ d17^d21^d25^d29
- c6 = ^d[3:0] ^ ^d[11:8] ^ d18^d22^d26^d30
- c7 = ^d[7:4] ^ ^d[15:12] ^ d19^d23^d27^d31
REQ-018 SHALL store each accepted codeword {en, c, d} in a 2-entry FIFO; a word is accepted when in_valid & in_ready.
REQ-019 SHALL drive in_ready = (occupancy < 2) from registered state only; no combinational path from out_ready.
REQ-020 SHALL drive out_valid = (occupancy > 0), with data_out/check_out/en_out showing the head entry.
REQ-021 SHALL present a word accepted at edge N on the outputs after edge N when the FIFO was empty (1-cycle latency).
REQ-022 SHALL, on simultaneous accept and deliver, leave occupancy unchanged and preserve word order.
REQ-023 SHALL keep the head stable while out_valid & ~out_ready.
REQ-024 SHALL apply a one-shot injection as follows:
- inj_arm with inj_bit <= 39 sets inj_pending.
- The next accepted word has the selected codeword bit inverted after encoding, and inj_pending clears on that same edge.
- inj_arm with inj_bit >= 40 is ignored.
- inj_arm while already pending overwrites the stored bit index.
REQ-025 SHALL, when inj_arm arrives in the same cycle as an acceptance, apply the injection to the following word, not the current one.
REQ-026 SHALL increment word_cnt on each out_valid & out_ready, saturating at all-ones.

Reset
REQ-027 SHALL, when rst is high at a clock edge, empty the FIFO, clear inj_pending and the stored index, and zero word_cnt.
REQ-028 SHALL therefore have in_ready=1 and out_valid=0 after reset.
REQ-029 SHALL discard any in-flight word on a mid-operation reset without delivering it, and ignore handshakes during the reset cycle.

Verification
REQ-030 SHALL cover encoding: data_in 0x00000001, 0x00010000, 0xFFFFFFFF, 0x00000000 -> check_out 0x51, 0x15, 0x00, 0x00 respectively.
REQ-031 SHALL cover latency and flow-through: out_ready=1, one word per cycle -> each word on the outputs one cycle after acceptance, in_ready constantly 1, word_cnt matching the count of words.
REQ-032 SHALL cover backpressure: out_ready=0, three words offered -> first two accepted, in_ready=0 after the second; release out_ready -> words delivered in order, the third accepted after the first is delivered.
REQ-033 SHALL cover injection: inj_arm with inj_bit=32, then data_in=0 -> check_out 0x01, inj_pending 1->0; inj_bit=5 with data 0 -> data_out 0x00000020, check_out 0x00; inj_bit=45 -> no effect.
REQ-034 SHALL cover reset mid-operation: rst with 2 words buffered and injection pending -> next cycle out_valid=0, in_ready=1, inj_pending=0, word_cnt=0.
REQ-035 SHALL cover counter saturation: CNT_W=4, 20 words delivered -> word_cnt=15.
